// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: opcode and FSM state encodings.
// Used by the datapath and its testbench.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_ADD = 3'b011,
    OP_SUB = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Only ADD and SUB propagate a carry between bit positions.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice, gate-level. Reserved opcodes decode to no function,
// so they yield r_i=0 and c_out=0.
module alu_bit_slice (
  input  logic       a_i,
  input  logic       b_i,
  input  logic       c_in,
  input  logic [2:0] op,
  output logic       r_i,
  output logic       c_out
);

  logic n0_s, n1_s, n2_s;
  logic is_and_s, is_or_s, is_xor_s, is_add_s, is_sub_s, is_arith_s;
  logic bx_s, ab_s, aob_s, axb_s, p_s, sum_s, g_s, pc_s, co_raw_s;
  logic t_and_s, t_or_s, t_xor_s, t_ar_s;

  not u_n0 (n0_s, op[0]);
  not u_n1 (n1_s, op[1]);
  not u_n2 (n2_s, op[2]);

  and u_dec_and (is_and_s, n2_s,  n1_s,  n0_s);
  and u_dec_or  (is_or_s,  n2_s,  n1_s,  op[0]);
  and u_dec_xor (is_xor_s, n2_s,  op[1], n0_s);
  and u_dec_add (is_add_s, n2_s,  op[1], op[0]);
  and u_dec_sub (is_sub_s, op[2], n1_s,  n0_s);
  or  u_dec_ar  (is_arith_s, is_add_s, is_sub_s);

  // Subtraction inverts b here; the +1 comes from the preloaded carry.
  xor u_binv (bx_s, b_i, is_sub_s);

  and u_ab  (ab_s,  a_i, b_i);
  or  u_aob (aob_s, a_i, b_i);
  xor u_axb (axb_s, a_i, b_i);

  xor u_p   (p_s,   a_i, bx_s);
  xor u_sum (sum_s, p_s, c_in);
  and u_g   (g_s,   a_i, bx_s);
  and u_pc  (pc_s,  p_s, c_in);
  or  u_co  (co_raw_s, g_s, pc_s);
  and u_cog (c_out, co_raw_s, is_arith_s);

  and u_t0 (t_and_s, is_and_s,   ab_s);
  and u_t1 (t_or_s,  is_or_s,    aob_s);
  and u_t2 (t_xor_s, is_xor_s,   axb_s);
  and u_t3 (t_ar_s,  is_arith_s, sum_s);
  or  u_r  (r_i, t_and_s, t_or_s, t_xor_s, t_ar_s);

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU: operands shift out LSB first through a single bit slice,
// result shifts in at the MSB; valid/ready handshake on both sides.
module serial_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_r;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] res_sr_r;
  logic [2:0]       op_r;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic             zero_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             r_s;
  logic             c_s;
  logic [WIDTH-1:0] res_next_s;

  alu_bit_slice u_slice (
    .a_i   (a_sr_r[0]),
    .b_i   (b_sr_r[0]),
    .c_in  (carry_r),
    .op    (op_r),
    .r_i   (r_s),
    .c_out (c_s)
  );

  assign res_next_s = {r_s, res_sr_r[WIDTH-1:1]};

  // Control FSM and serial datapath; every output comes straight from a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      a_sr_r      <= '0;
      b_sr_r      <= '0;
      res_sr_r    <= '0;
      op_r        <= 3'b000;
      cnt_r       <= '0;
      carry_r     <= 1'b0;
      zero_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_sr_r     <= a;
            b_sr_r     <= b;
            op_r       <= op;
            cnt_r      <= '0;
            carry_r    <= (op == OP_SUB);
            zero_r     <= 1'b0;
            in_ready_r <= 1'b0;
            state_r    <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
          b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
          res_sr_r <= res_next_s;
          cnt_r    <= cnt_r + CW'(1'b1);
          if (is_arith(op_r)) begin
            carry_r <= c_s;
          end else begin
            carry_r <= carry_r;
          end
          // Flags are finalised on the edge that produces the MSB.
          if (cnt_r == LAST_BIT) begin
            zero_r      <= (res_next_s == '0);
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out       = res_sr_r;
  assign carry     = carry_r;
  assign zero      = zero_r;

endmodule

// File: tb/tb_serial_alu.sv
// Scoreboard bench for serial_alu: expected results are queued at issue and
// compared when out_valid rises.
module tb_serial_alu;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         z;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    exp_t         e;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         carry;
  logic         zero;

  int   n_checks;
  int   n_pass;
  exp_t exp_q[$];

  serial_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .carry     (carry),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: plain integer arithmetic on WIDTH+1 bits.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] o);
    logic [W:0] s;
    exp_t e;
    case (o)
      3'b000:  s = {1'b0, x & y};
      3'b001:  s = {1'b0, x | y};
      3'b010:  s = {1'b0, x ^ y};
      3'b011:  s = {1'b0, x} + {1'b0, y};
      3'b100:  s = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
      default: s = '0;
    endcase
    e.r = s[W-1:0];
    e.c = s[W];
    e.z = (s[W-1:0] == '0);
    return e;
  endfunction

  // Presents one operation in IDLE and queues its expected result.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [2:0] top, input exp_t e);
    a = ta;
    b = tb;
    op = top;
    in_valid = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    op = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, out, carry, zero} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0})
      $display("FAIL reset_state: got rdy=%b vld=%b out=%h c=%b z=%b, want rdy=1 vld=0 out=00 c=0 z=0",
               in_ready, out_valid, out, carry, zero);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL reset_release: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_spec_vectors;
    vec_t vecs[6];
    int   cyc;
    exp_t e;
    vecs[0] = '{a: 8'hFF, b: 8'h01, op: 3'b011, e: '{r: 8'h00, c: 1'b1, z: 1'b1}};
    vecs[1] = '{a: 8'h05, b: 8'h07, op: 3'b100, e: '{r: 8'hFE, c: 1'b0, z: 1'b0}};
    vecs[2] = '{a: 8'h07, b: 8'h05, op: 3'b100, e: '{r: 8'h02, c: 1'b1, z: 1'b0}};
    vecs[3] = '{a: 8'hA0, b: 8'h0A, op: 3'b001, e: '{r: 8'hAA, c: 1'b0, z: 1'b0}};
    vecs[4] = '{a: 8'hA0, b: 8'h0A, op: 3'b000, e: '{r: 8'h00, c: 1'b0, z: 1'b1}};
    vecs[5] = '{a: 8'hFF, b: 8'h0F, op: 3'b010, e: '{r: 8'hF0, c: 1'b0, z: 1'b0}};
    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].e);
      wait_valid(cyc);
      e = exp_q.pop_front();
      n_checks++;
      if (cyc !== W) $display("FAIL vec%0d_latency: got %0d cycles, want %0d", i, cyc, W);
      else n_pass++;
      n_checks++;
      if ({out, carry, zero} !== {e.r, e.c, e.z})
        $display("FAIL vec%0d_result: got out=%h c=%b z=%b, want out=%h c=%b z=%b", i, out, carry, zero, e.r, e.c, e.z);
      else n_pass++;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++;
      if ({in_ready, out_valid} !== 2'b10)
        $display("FAIL vec%0d_release: got rdy=%b vld=%b, want rdy=1 vld=0", i, in_ready, out_valid);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure;
    int   cyc;
    exp_t e;
    issue(8'h3C, 8'h0F, 3'b011, '{r: 8'h4B, c: 1'b0, z: 1'b0});
    wait_valid(cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (cyc !== W) $display("FAIL bp_latency: got %0d cycles, want %0d", cyc, W);
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
      op = 3'b011;
      @(negedge clk);
      n_checks++;
      if ({out_valid, in_ready, out, carry, zero} !== {1'b1, 1'b0, e.r, e.c, e.z})
        $display("FAIL bp_hold%0d: got vld=%b rdy=%b out=%h c=%b z=%b, want vld=1 rdy=0 out=%h c=%b z=%b",
                 k, out_valid, in_ready, out, carry, zero, e.r, e.c, e.z);
      else n_pass++;
    end
    // in_valid stays high across the release edge; it must not be taken.
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL bp_release: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run;
    int   cyc;
    exp_t e;
    issue(8'h12, 8'h34, 3'b011, '{r: 8'h46, c: 1'b0, z: 1'b0});
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_front());
    n_checks++;
    if ({out_valid, in_ready, out, carry, zero} !== {1'b0, 1'b1, {W{1'b0}}, 1'b0, 1'b0})
      $display("FAIL midrun_reset: got vld=%b rdy=%b out=%h c=%b z=%b, want vld=0 rdy=1 out=00 c=0 z=0",
               out_valid, in_ready, out, carry, zero);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    issue(8'h12, 8'h34, 3'b011, '{r: 8'h46, c: 1'b0, z: 1'b0});
    wait_valid(cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (cyc !== W) $display("FAIL midrun_latency: got %0d cycles, want %0d", cyc, W);
    else n_pass++;
    n_checks++;
    if ({out, carry, zero} !== {e.r, e.c, e.z})
      $display("FAIL midrun_result: got out=%h c=%b z=%b, want out=%h c=%b z=%b", out, carry, zero, e.r, e.c, e.z);
    else n_pass++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reserved;
    int   cyc;
    exp_t e;
    issue(8'hFF, 8'hFF, 3'b111, '{r: 8'h00, c: 1'b0, z: 1'b1});
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      a = W'($urandom);
      b = W'($urandom);
      op = 3'($urandom_range(0, 4));
      @(negedge clk);
      cyc++;
    end
    e = exp_q.pop_front();
    n_checks++;
    if (cyc !== W) $display("FAIL reserved_latency: got %0d cycles, want %0d", cyc, W);
    else n_pass++;
    n_checks++;
    if ({out, carry, zero} !== {e.r, e.c, e.z})
      $display("FAIL reserved_result: got out=%h c=%b z=%b, want out=%h c=%b z=%b", out, carry, zero, e.r, e.c, e.z);
    else n_pass++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // out_ready is held high throughout, including during RUN.
  task automatic test_back_to_back;
    int           cyc;
    exp_t         e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [2:0]   ro;
    out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      ro = 3'($urandom_range(0, 7));
      issue(ra, rb, ro, model(ra, rb, ro));
      wait_valid(cyc);
      e = exp_q.pop_front();
      n_checks++;
      if (cyc !== W || {out, carry, zero} !== {e.r, e.c, e.z})
        $display("FAIL b2b%0d: op=%b a=%h b=%h got out=%h c=%b z=%b lat=%0d, want out=%h c=%b z=%b lat=%0d",
                 i, ro, ra, rb, out, carry, zero, cyc, e.r, e.c, e.z, W);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({in_ready, out_valid} !== 2'b10)
        $display("FAIL b2b%0d_release: got rdy=%b vld=%b, want rdy=1 vld=0", i, in_ready, out_valid);
      else n_pass++;
    end
    out_ready = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    op        = 3'b000;
    test_reset();
    test_spec_vectors();
    test_backpressure();
    test_reset_mid_run();
    test_reserved();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
